// File: rtl/sort_check_pkg.sv
// sort_check_pkg
//   Shared types and helpers for the sorter stream checker.
//   - state_t         : frame phase of the checker (IDLE, FILL, DRAIN, CHECK)
//   - sum_width()     : width of a signature accumulator that cannot wrap
//                       over one frame of 'size' words of 'width' bits
//   - order_violation : true when 'cur' breaks the required ordering
//                       relative to 'prev' (equal words are always legal)
package sort_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Widest data word the ordering helper accepts; callers zero-extend.
  localparam int MAX_WIDTH = 256;

  // One guard bit on top of the log2(size) growth keeps the sum exact.
  function automatic int sum_width(input int size, input int width);
    return width + $clog2(size) + 1;
  endfunction

  function automatic logic order_violation(
    input logic                 descend,
    input logic [MAX_WIDTH-1:0] cur,
    input logic [MAX_WIDTH-1:0] prev
  );
    return descend ? (cur > prev) : (cur < prev);
  endfunction

endpackage

// File: rtl/sort_check_accum.sv
// sort_check_accum
//   Word counter plus running unsigned sum for one side of the sorter
//   stream.  'clear' restarts the frame; if 'add' is high in the same
//   cycle the new frame starts with that word already counted.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     clear    : start a new frame
//     add      : accumulate 'data' this cycle
//     data     : word to accumulate
//     cnt      : words accumulated in the current frame
//     sum      : running sum of those words
module sort_check_accum #(
  parameter int WIDTH = 32,
  parameter int CW    = 11,
  parameter int SW    = 43
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             add,
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    cnt,
  output logic [SW-1:0]    sum
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sum <= '0;
    end else if (clear) begin
      cnt <= add ? CW'(1) : '0;
      sum <= add ? SW'(data) : '0;
    end else if (add) begin
      cnt <= cnt + CW'(1);
      sum <= sum + SW'(data);
    end
  end

endmodule

// File: rtl/sort_stream_checker.sv
// sort_stream_checker
//   Watches the write and read sides of a systolic sorter and, per frame
//   of SIZE words, checks output ordering, word counts/protocol and the
//   multiset signature (sum of inputs == sum of outputs).
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     in_valid, in_data    : word written into the sorter
//     out_valid, out_data  : word read out of the sorter
//     busy                 : frame in progress (FILL/DRAIN/CHECK)
//     done                 : one-cycle pulse while the verdict is presented
//     pass                 : verdict of the last frame, held until next frame
//     err_order            : an ordering violation was seen this frame
//     err_count            : count or protocol violation this frame
//     err_sum              : input and output sums differ
//     bad_index            : output index of the first ordering violation
//   Build option:
//     SORT_CHECK_TIMEOUT_EN : adds a DRAIN watchdog; TIMEOUT cycles after the
//                             last output word the frame is closed with
//                             err_count set.  Without it DRAIN waits forever.
module sort_stream_checker
  import sort_check_pkg::*;
#(
  parameter int SIZE    = 1024,
  parameter int WIDTH   = 32,
  parameter bit DESCEND = 1'b0,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    out_valid,
  input  logic [WIDTH-1:0]        out_data,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    err_order,
  output logic                    err_count,
  output logic                    err_sum,
  output logic [$clog2(SIZE)-1:0] bad_index
);

  localparam int IW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE) + 1;
  localparam int SW = sum_width(SIZE, WIDTH);
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  state_t state, state_next;

  logic          start, in_add, out_add;
  logic          fill_last, drain_done, timeout_hit;
  logic          violation, late_in, sum_mismatch, check_pass;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [SW-1:0] in_sum, out_sum;
  logic [WIDTH-1:0] prev_data;

  logic          err_order_q, err_count_q, err_sum_q, pass_q;
  logic [IW-1:0] bad_index_q;

  assign start   = (state == IDLE) && in_valid;
  assign in_add  = start || ((state == FILL) && in_valid);
  // Outputs arriving while still filling are counted and ordered as well,
  // so an early sorter is flagged once rather than cascading into order/sum
  // errors too.
  assign out_add = out_valid && ((state == FILL) || (state == DRAIN));

  sort_check_accum #(.WIDTH(WIDTH), .CW(CW), .SW(SW)) u_in_accum (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .add   (in_add),
    .data  (in_data),
    .cnt   (in_cnt),
    .sum   (in_sum)
  );

  sort_check_accum #(.WIDTH(WIDTH), .CW(CW), .SW(SW)) u_out_accum (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .add   (out_add),
    .data  (out_data),
    .cnt   (out_cnt),
    .sum   (out_sum)
  );

  assign fill_last  = (state == FILL) && in_valid && (in_cnt == SIZE_C - CW'(1));
  // Early outputs during FILL may already have completed the count.
  assign drain_done = (state == DRAIN) &&
                      ((out_cnt >= SIZE_C) || (out_valid && (out_cnt == SIZE_C - CW'(1))));

  assign violation = out_add && (out_cnt != '0) &&
                     order_violation(DESCEND, MAX_WIDTH'(out_data), MAX_WIDTH'(prev_data));

  // Sums are final in CHECK, so the verdict is formed combinationally there
  // and captured on the way back to IDLE.
  assign late_in      = (state == CHECK) && in_valid;
  assign sum_mismatch = (in_sum != out_sum);
  assign check_pass   = !(err_order_q || err_count_q || late_in || sum_mismatch);

`ifdef SORT_CHECK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  // wd_cnt is the number of cycles since the last output word (or since
  // DRAIN was entered); CHECK lands exactly TIMEOUT cycles after that word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state != DRAIN) || out_valid) begin
      wd_cnt <= TW'(1);
    end else if (wd_cnt < TW'(TIMEOUT)) begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state == DRAIN) && !out_valid && !drain_done &&
                       (wd_cnt >= TW'(TIMEOUT - 1));
`else
  // No watchdog: TIMEOUT only survives so the parameter list stays the same
  // in both builds; this folds to constant 0 for any legal TIMEOUT.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // Frame phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = FILL;
      FILL:    if (fill_last) state_next = DRAIN;
      DRAIN:   if (drain_done || timeout_hit) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Previous output word, used for the pairwise ordering compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_data <= '0;
    end else if (out_add) begin
      prev_data <= out_data;
    end
  end

  // Per-frame error flags and held verdict; everything restarts when the
  // first word of a new frame is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_order_q <= 1'b0;
      err_count_q <= 1'b0;
      err_sum_q   <= 1'b0;
      pass_q      <= 1'b0;
      bad_index_q <= '0;
    end else if (start) begin
      err_order_q <= 1'b0;
      err_count_q <= 1'b0;
      err_sum_q   <= 1'b0;
      pass_q      <= 1'b0;
      bad_index_q <= '0;
    end else begin
      if (violation && !err_order_q) begin
        err_order_q <= 1'b1;
        bad_index_q <= out_cnt[IW-1:0];
      end
      if (((state == FILL) && out_valid) || ((state == DRAIN) && in_valid) ||
          late_in || timeout_hit) begin
        err_count_q <= 1'b1;
      end
      if (state == CHECK) begin
        err_sum_q <= sum_mismatch;
        pass_q    <= check_pass;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == CHECK);
  assign pass      = (state == CHECK) ? check_pass : pass_q;
  assign err_order = err_order_q;
  assign err_count = err_count_q || late_in;
  assign err_sum   = (state == CHECK) ? sum_mismatch : err_sum_q;
  assign bad_index = bad_index_q;

endmodule

// File: tb/tb_sort_stream_checker.sv
// tb_sort_stream_checker
//   Scoreboard bench for sort_stream_checker (SIZE=4, WIDTH=8, ascending).
//   Each frame's expected verdict is derived from the word lists alone and
//   queued; a monitor pops and compares whenever done is seen.
//   Build option honoured: SORT_CHECK_TIMEOUT_EN (adds a short-frame case).
module tb_sort_stream_checker;

  localparam int SIZE    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  typedef logic [WIDTH-1:0] word_t;
  typedef word_t frame_t [SIZE];

  typedef struct {
    bit     pass;
    bit     eo;
    bit     ec;
    bit     es;
    int     bidx;
    longint done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_valid;
  word_t       in_data, out_data;
  logic        busy, done, pass, err_order, err_count, err_sum;
  logic [1:0]  bad_index;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  exp_t   exp_q[$];

  sort_stream_checker #(
    .SIZE    (SIZE),
    .WIDTH   (WIDTH),
    .DESCEND (1'b0),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_order (err_order),
    .err_count (err_count),
    .err_sum   (err_sum),
    .bad_index (bad_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected verdict from the frame's word lists: first descending pair,
  // multiset sums, and whether the frame broke the protocol or was short.
  function automatic exp_t model(input frame_t ins, input frame_t outs,
                                 input int n_out, input bit proto);
    exp_t e;
    int   si = 0;
    int   so = 0;
    e.eo = 1'b0;
    e.bidx = 0;
    e.done_cyc = 0;
    for (int i = 0; i < SIZE; i++) si += int'(ins[i]);
    for (int i = 0; i < n_out; i++) so += int'(outs[i]);
    for (int i = 1; i < n_out; i++) begin
      if (!e.eo && outs[i] < outs[i-1]) begin
        e.eo = 1'b1;
        e.bidx = i;
      end
    end
    e.ec = proto || (n_out != SIZE);
    e.es = (si != so);
    e.pass = !(e.eo || e.ec || e.es);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1, required done=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check_output("done_cycle", cyc, e.done_cyc);
        check_output("pass", longint'(pass), longint'(e.pass));
        check_output("err_order", longint'(err_order), longint'(e.eo));
        check_output("err_count", longint'(err_count), longint'(e.ec));
        check_output("err_sum", longint'(err_sum), longint'(e.es));
        check_output("bad_index", longint'(bad_index), longint'(e.bidx));
      end
    end
  end

  task automatic step(input bit iv, input word_t id, input bit ov, input word_t od);
    in_valid  = iv;
    in_data   = id;
    out_valid = ov;
    out_data  = od;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0);
  endtask

  // mode 0: clean protocol, 1: first output overlaps the last input (FILL),
  // 2: stray input during DRAIN, 3: stray input in the verdict cycle.
  task automatic apply_stimulus(input frame_t ins, input frame_t outs,
                                input int n_out, input int mode);
    exp_t e;
    int   first_out;
    e = model(ins, outs, n_out, mode != 0);
    first_out = 0;
    for (int i = 0; i < SIZE; i++) begin
      idle($urandom_range(0, 2));
      if (mode == 1 && i == SIZE - 1) begin
        step(1'b1, ins[i], 1'b1, outs[0]);
        first_out = 1;
      end else begin
        step(1'b1, ins[i], 1'b0, '0);
      end
    end
    idle($urandom_range(0, 3));
    if (mode == 2) step(1'b1, word_t'($urandom), 1'b0, '0);
    for (int j = first_out; j < n_out; j++) begin
      idle($urandom_range(0, 2));
      if (j == n_out - 1) begin
        e.done_cyc = cyc + ((n_out == SIZE) ? 1 : TIMEOUT);
        exp_q.push_back(e);
      end
      step(1'b0, '0, 1'b1, outs[j]);
    end
    if (mode == 3) step(1'b1, word_t'($urandom), 1'b0, '0);
    idle((n_out == SIZE) ? 2 : TIMEOUT + 2);
    check_output("busy_after", longint'(busy), 0);
    check_output("pass_held", longint'(pass), longint'(e.pass));
    check_output("bad_index_held", longint'(bad_index), longint'(e.bidx));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, longint'(busy), 0);
    check_output({tag, "_done"}, longint'(done), 0);
    check_output({tag, "_pass"}, longint'(pass), 0);
    check_output({tag, "_err_order"}, longint'(err_order), 0);
    check_output({tag, "_err_count"}, longint'(err_count), 0);
    check_output({tag, "_err_sum"}, longint'(err_sum), 0);
    check_output({tag, "_bad_index"}, longint'(bad_index), 0);
  endtask

  initial begin
    frame_t ins, outs;
    word_t  t;
    int     mode, k, wait_cnt;

    rst = 1'b1;
    in_valid = 1'b0;
    out_valid = 1'b0;
    in_data = '0;
    out_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    idle(1);

    $display("[TB] directed frames");
    apply_stimulus('{8'd7, 8'd3, 8'd9, 8'd1}, '{8'd1, 8'd3, 8'd7, 8'd9}, SIZE, 0);
    apply_stimulus('{8'd5, 8'd5, 8'd2, 8'd2}, '{8'd2, 8'd2, 8'd5, 8'd5}, SIZE, 0);
    apply_stimulus('{8'd7, 8'd3, 8'd9, 8'd1}, '{8'd1, 8'd7, 8'd3, 8'd9}, SIZE, 0);
    apply_stimulus('{8'd7, 8'd3, 8'd9, 8'd1}, '{8'd1, 8'd3, 8'd7, 8'd8}, SIZE, 0);
    apply_stimulus('{8'd7, 8'd3, 8'd9, 8'd1}, '{8'd1, 8'd3, 8'd7, 8'd9}, SIZE, 1);
    apply_stimulus('{8'd7, 8'd3, 8'd9, 8'd1}, '{8'd1, 8'd3, 8'd7, 8'd9}, SIZE, 2);
    apply_stimulus('{8'd7, 8'd3, 8'd9, 8'd1}, '{8'd1, 8'd3, 8'd7, 8'd9}, SIZE, 3);
    apply_stimulus('{8'd0, 8'd255, 8'd255, 8'd0}, '{8'd0, 8'd0, 8'd255, 8'd255}, SIZE, 0);

    $display("[TB] abort frame with reset");
    step(1'b1, 8'd7, 1'b0, '0);
    step(1'b1, 8'd3, 1'b0, '0);
    step(1'b1, 8'd9, 1'b0, '0);
    step(1'b1, 8'd1, 1'b0, '0);
    step(1'b0, '0, 1'b1, 8'd1);
    step(1'b0, '0, 1'b1, 8'd3);
    check_output("busy_mid_frame", longint'(busy), 1);
    rst = 1'b1;
    idle(2);
    check_reset_values("abort");
    rst = 1'b0;
    idle(1);
    apply_stimulus('{8'd7, 8'd3, 8'd9, 8'd1}, '{8'd1, 8'd3, 8'd7, 8'd9}, SIZE, 0);

`ifdef SORT_CHECK_TIMEOUT_EN
    $display("[TB] short frame closed by watchdog");
    apply_stimulus('{8'd7, 8'd3, 8'd9, 8'd1}, '{8'd1, 8'd3, 8'd7, 8'd0}, 3, 0);
`endif

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < SIZE; i++) ins[i] = word_t'($urandom);
      outs = ins;
      for (int a = 0; a < SIZE - 1; a++) begin
        for (int b = 0; b < SIZE - 1 - a; b++) begin
          if (outs[b] > outs[b+1]) begin
            t = outs[b];
            outs[b] = outs[b+1];
            outs[b+1] = t;
          end
        end
      end
      k = $urandom_range(0, SIZE - 2);
      case ($urandom_range(0, 5))
        1: begin t = outs[k]; outs[k] = outs[k+1]; outs[k+1] = t; end
        2: outs[k] = outs[k] + 8'd1;
        3: begin
          for (int i = 0; i < SIZE / 2; i++) begin
            t = outs[i];
            outs[i] = outs[SIZE-1-i];
            outs[SIZE-1-i] = t;
          end
        end
        default: ;
      endcase
      mode = $urandom_range(0, 6);
      if (mode > 3) mode = 0;
      apply_stimulus(ins, outs, SIZE, mode);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      idle(1);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL pending_verdicts: got %0d undelivered, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
